// File: rtl/mmio_timer_responder.sv
// ---------------------------------------------------------------------------
// mmio_timer_responder
//
// Memory-mapped peripheral that answers MEM-stage loads and stores that fall
// inside a six-word window starting at BASE_ADDR. It holds the LED and display
// registers, a reloadable 32-bit interval timer with an interrupt request, and
// a free-running cycle counter.
//
// Register map (byte offset from BASE_ADDR, Address[1:0] ignored):
//   0x00 TH       reload value                        R/W
//   0x04 TL       timer counter                       R/W
//   0x08 TCON     bit0 EN, bit1 IE, bit2 IS           R/W
//   0x0C LED      16-bit LED register                 R/W
//   0x10 DIGITS   16-bit display value                R/W
//   0x14 SYSTICK  free-running cycle counter          R/O
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   Address    byte address from the MEM-stage ALU result
//   WriteData  store data
//   MemRead    load request (only acted on when hit)
//   MemWrite   store request (only acted on when hit)
//   ReadData   combinational load data, zero unless MemRead & hit
//   hit        Address lies inside [BASE_ADDR, BASE_ADDR + 0x18)
//   led        LED register
//   digits     display value register
//   irq        timer interrupt request (IE & IS)
// ---------------------------------------------------------------------------
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic [15:0] led,
    output logic [15:0] digits,
    output logic        irq
);

    localparam logic [31:0] PRE_LAST = 32'(PRESCALE - 1);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic        r_en;
    logic        r_ie;
    logic        r_is;
    logic [15:0] r_led;
    logic [15:0] r_digits;
    logic [31:0] r_systick;
    logic [31:0] r_pre;

    logic [31:0] w_offset;
    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_tick;
    logic        w_ovf;
    logic        w_set_is;
    logic [31:0] w_rdata;

    // Subtracting first makes addresses below the base wrap to a large
    // offset, so a single unsigned compare covers both window edges.
    assign w_offset = Address - BASE_ADDR;
    assign w_hit    = (w_offset < 32'h0000_0018);
    assign w_idx    = w_offset[4:2];
    assign w_wr     = MemWrite & w_hit;

    assign w_tick   = r_en && (r_pre == PRE_LAST);
    assign w_ovf    = w_tick && (r_tl == 32'hFFFF_FFFF);
    // Interrupt status is set from the IE value in force before any
    // concurrent TCON write.
    assign w_set_is = w_ovf & r_ie;

    always_comb begin
        w_rdata = 32'h0;
        if (MemRead && w_hit) begin
            case (w_idx)
                3'd0:    w_rdata = r_th;
                3'd1:    w_rdata = r_tl;
                3'd2:    w_rdata = {29'h0, r_is, r_ie, r_en};
                3'd3:    w_rdata = {16'h0, r_led};
                3'd4:    w_rdata = {16'h0, r_digits};
                3'd5:    w_rdata = r_systick;
                default: w_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th      <= 32'h0;
            r_tl      <= 32'h0;
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_is      <= 1'b0;
            r_led     <= 16'h0;
            r_digits  <= 16'h0;
            r_systick <= 32'h0;
            r_pre     <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'h1;

            if (!r_en || w_tick) begin
                r_pre <= 32'h0;
            end else begin
                r_pre <= r_pre + 32'h1;
            end

            if (w_wr && (w_idx == 3'd0)) begin
                r_th <= WriteData;
            end

            // A CPU store to TL takes priority over the timer increment.
            if (w_wr && (w_idx == 3'd1)) begin
                r_tl <= WriteData;
            end else if (w_tick) begin
                r_tl <= w_ovf ? r_th : (r_tl + 32'h1);
            end

            // Hardware setting of IS wins over a concurrent software clear.
            if (w_wr && (w_idx == 3'd2)) begin
                r_en <= WriteData[0];
                r_ie <= WriteData[1];
                r_is <= WriteData[2] | w_set_is;
            end else if (w_set_is) begin
                r_is <= 1'b1;
            end

            if (w_wr && (w_idx == 3'd3)) begin
                r_led <= WriteData[15:0];
            end

            if (w_wr && (w_idx == 3'd4)) begin
                r_digits <= WriteData[15:0];
            end
        end
    end

    assign ReadData = w_rdata;
    assign hit      = w_hit;
    assign led      = r_led;
    assign digits   = r_digits;
    assign irq      = r_ie & r_is;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// ---------------------------------------------------------------------------
// Testbench for mmio_timer_responder. Two instances share the address and
// data buses: u_dut1 uses PRESCALE=1 and u_dut4 uses PRESCALE=4; sel4 routes
// the load/store strobes to one of them. Expected load data is queued when
// a load is issued and popped by the monitor when the selected instance
// presents MemRead & hit. Expected values of the level outputs (led, digits,
// irq, hit, ReadData outside the window) are queued as observations and
// compared by the same monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_mmio_timer_responder;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIG  = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    localparam int OB_LED = 0;
    localparam int OB_DIG = 1;
    localparam int OB_IRQ = 2;
    localparam int OB_HIT = 3;
    localparam int OB_RD  = 4;

    typedef struct {
        int          id;
        logic [31:0] v;
        string       nm;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        sel4;
    logic        done;
    logic [31:0] Address;
    logic [31:0] WriteData;

    logic [31:0] rd1, rd4;
    logic        hit1, hit4, irq1, irq4;
    logic [15:0] led1, led4, dig1, dig4;

    item_t rd_q[$];
    item_t ob_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    mmio_timer_responder #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead & ~sel4),
        .MemWrite  (MemWrite & ~sel4),
        .ReadData  (rd1),
        .hit       (hit1),
        .led       (led1),
        .digits    (dig1),
        .irq       (irq1)
    );

    mmio_timer_responder #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead & sel4),
        .MemWrite  (MemWrite & sel4),
        .ReadData  (rd4),
        .hit       (hit4),
        .led       (led4),
        .digits    (dig4),
        .irq       (irq4)
    );

    task automatic expect_rd(input string nm, input logic [31:0] v);
        rd_q.push_back('{0, v, nm});
    endtask

    task automatic obs(input int id, input logic [31:0] v, input string nm);
        ob_q.push_back('{id, v, nm});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        Address = a;
        MemRead = 1'b1;
        expect_rd(nm, e);
        @(posedge clk);
        #1;
        MemRead = 1'b0;
    endtask

    // Load+store to an address outside the window: nothing may respond.
    task automatic out_of_window(input logic [31:0] a, input string nm);
        Address   = a;
        WriteData = 32'hFFFF_FFFF;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        obs(OB_HIT, 32'h0, {nm, "_hit"});
        obs(OB_RD,  32'h0, {nm, "_rdata"});
        @(posedge clk);
        #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        while (ob_q.size() > 0) begin
            it = ob_q.pop_front();
            case (it.id)
                OB_LED:  act = {16'h0, led1};
                OB_DIG:  act = {16'h0, dig1};
                OB_IRQ:  act = {31'h0, irq1};
                OB_HIT:  act = {31'h0, hit1};
                default: act = rd1;
            endcase
            n_tests++;
            if (act !== it.v) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", it.nm, act, it.v);
            end
        end
        if (MemRead && (sel4 ? hit4 : hit1)) begin
            act = sel4 ? rd4 : rd1;
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_load: got %h, expected no load", act);
            end else begin
                it = rd_q.pop_front();
                if (act !== it.v) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", it.nm, act, it.v);
                end
            end
        end
        if (done) begin
            n_tests++;
            if (rd_q.size() != 0) begin
                n_fail++;
                $display("FAIL loads_outstanding: got %0d, expected 0", rd_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        sel4      = 1'b0;
        done      = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;

        // Reset, then SYSTICK ten cycles apart
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        obs(OB_LED, 32'h0, "rst_led");
        obs(OB_DIG, 32'h0, "rst_digits");
        obs(OB_IRQ, 32'h0, "rst_irq");
        cycles(1);
        bus_rd(A_TICK, 32'd1, "systick_c1");
        cycles(9);
        bus_rd(A_TICK, 32'd11, "systick_c11");

        // LED / DIGITS store and load
        bus_wr(A_LED, 32'hABCD_1234);
        obs(OB_LED, 32'h0000_1234, "led_store");
        bus_rd(A_LED, 32'h0000_1234, "led_load");
        bus_wr(A_DIG, 32'h0000_5678);
        obs(OB_DIG, 32'h0000_5678, "digits_store");
        bus_rd(A_DIG, 32'h0000_5678, "digits_load");

        // Timer overflow and reload, PRESCALE=1
        bus_wr(A_TH, 32'hFFFF_FFFC);
        bus_wr(A_TL, 32'hFFFF_FFFE);
        bus_wr(A_TCON, 32'h3);
        bus_rd(A_TL, 32'hFFFF_FFFE, "tl_start");
        bus_rd(A_TL, 32'hFFFF_FFFF, "tl_max");
        obs(OB_IRQ, 32'h1, "irq_overflow");
        bus_rd(A_TL, 32'hFFFF_FFFC, "tl_reload");
        bus_rd(A_TCON, 32'h7, "tcon_is_set");
        bus_wr(A_TCON, 32'h3);
        obs(OB_IRQ, 32'h0, "irq_sw_clear");

        // TCON write of 3 coincides with the next overflow: IS must survive
        bus_wr(A_TCON, 32'h3);
        obs(OB_IRQ, 32'h1, "irq_tcon_collide");
        bus_rd(A_TCON, 32'h7, "tcon_collide");

        // Store to TL in a tick cycle: store wins
        bus_wr(A_TL, 32'h0000_0010);
        bus_rd(A_TL, 32'h0000_0010, "tl_collide");
        bus_rd(A_TL, 32'h0000_0011, "tl_after_collide");
        bus_wr(A_TCON, 32'h0);
        obs(OB_IRQ, 32'h0, "irq_disabled");
        bus_rd(A_TL, 32'h0000_0013, "tl_disable");
        cycles(3);
        bus_rd(A_TL, 32'h0000_0013, "tl_frozen");

        // Prescaler, PRESCALE=4 instance
        sel4 = 1'b1;
        bus_wr(A_TL, 32'h0);
        bus_wr(A_TCON, 32'h1);
        cycles(3);
        bus_rd(A_TL, 32'd0, "pre4_c3");
        bus_rd(A_TL, 32'd1, "pre4_c4");
        cycles(2);
        bus_rd(A_TL, 32'd1, "pre4_c7");
        bus_rd(A_TL, 32'd2, "pre4_c8");
        bus_wr(A_TCON, 32'h0);
        cycles(6);
        bus_rd(A_TL, 32'd2, "pre4_frozen");
        sel4 = 1'b0;

        // Decode edges
        out_of_window(32'h4000_0018, "addr_18");
        obs(OB_LED, 32'h0000_1234, "led_untouched");
        out_of_window(32'h3FFF_FFFC, "addr_below");
        out_of_window(32'h4000_0020, "addr_20");
        bus_rd(A_TH, 32'hFFFF_FFFC, "th_untouched");
        bus_rd(A_TL, 32'h0000_0013, "tl_untouched");
        bus_wr(32'h4000_0007, 32'h0000_0055);
        bus_rd(A_TL, 32'h0000_0055, "tl_unaligned");

        // Load and store together: load sees the old value
        Address   = A_LED;
        WriteData = 32'h0000_BEEF;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        expect_rd("rw_prewrite", 32'h0000_1234);
        @(posedge clk);
        #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        obs(OB_LED, 32'h0000_BEEF, "rw_led");

        // Reset in the middle of a count
        bus_wr(A_TL, 32'h5);
        bus_wr(A_TCON, 32'h7);
        obs(OB_IRQ, 32'h1, "irq_sw_set");
        cycles(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs(OB_IRQ, 32'h0, "irq_mid_reset");
        obs(OB_LED, 32'h0, "led_mid_reset");
        obs(OB_DIG, 32'h0, "digits_mid_reset");
        bus_rd(A_TL, 32'h0, "tl_mid_reset");
        bus_rd(A_TCON, 32'h0, "tcon_mid_reset");
        cycles(1);
        bus_rd(A_TL, 32'h0, "tl_stays_after_reset");

        done = 1'b1;
    end

endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
- Memory-mapped peripheral responder on the CPU data-memory port (MEM stage).
- Answers load/store requests from the pipeline in a fixed address window and holds the LED and display registers.
- Contains a reloadable 32-bit interval timer with an interrupt request, plus a free-running cycle counter.
- Top level muxes its ReadData into the MEM-stage load path when `hit` is asserted.

Parameters:
- BASE_ADDR, 32'h40000000, word-aligned base of the register window.
- PRESCALE, 1, clock cycles per timer increment (≥1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Address  input  32  byte address from MEM stage ALU result
- WriteData  input  32  store data
- MemRead  input  1  load request, qualified by hit
- MemWrite  input  1  store request, qualified by hit
- ReadData  output  32  load data, combinational
- hit  output  1  Address inside window [BASE_ADDR, BASE_ADDR+0x18)
- led  output  16  LED register
- digits  output  16  display value register, to display driver
- irq  output  1  timer interrupt request

Behaviour:
- Decode: offset = Address − BASE_ADDR; word index = offset[4:2]; Address[1:0] ignored.
- Register map, by offset:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON, R/W:
    - bit0 EN
    - bit1 IE
    - bit2 IS (interrupt status)
    - bits 31:3 read 0
  - 0x0C LED: R/W, 16 bits.
  - 0x10 DIGITS: R/W, 16 bits.
  - 0x14 SYSTICK: read-only.
- Read path:
  - ReadData is combinational, valid in the same cycle as MemRead & hit.
  - It returns 0 when MemRead=0 or hit=0.
  - Upper bits of 16-bit registers read 0.
- Write path:
  - A register updates at the rising edge when MemWrite & hit.
  - LED and DIGITS take WriteData[15:0].
  - Writes to SYSTICK are ignored.
- MemRead and MemWrite both high: the write happens; ReadData shows the pre-write value.
- Reset (synchronous):
  - TH, TL, TCON, LED, DIGITS and SYSTICK go to 0.
  - The prescale counter goes to 0.
  - irq=0 and digits=0 in the cycle after reset is sampled.
  - Reset mid-count abandons the count with no irq.
- SYSTICK: increments by 1 every cycle out of reset and wraps at 2^32.
- Prescaler:
  - While EN=1, the prescale counter counts 0..PRESCALE−1.
  - A tick is issued when the counter equals PRESCALE−1, then it returns to 0.
  - While EN=0, the counter is held at 0.
  - With PRESCALE=1, every enabled cycle is a tick.
- Timer on tick:
  - If TL==32'hFFFFFFFF: TL←TH; if IE=1, IS←1.
  - Otherwise TL←TL+1.
- Collisions:
  - A CPU write to TL in the same cycle as a tick: the CPU write wins and the increment is lost.
  - A CPU write to TCON in the same cycle as an overflow with IE=1: EN and IE take WriteData; IS takes WriteData[2] | 1 (hardware set wins, no lost interrupt).
  - Software clears IS by writing TCON with bit2=0.
- irq = IE & IS, registered-free (direct from TCON bits).
- Disabling EN freezes TL and leaves IS unchanged.
- Latency:
  - A store is visible to a load issued in the following cycle.
  - LED and DIGITS outputs change one cycle after the store cycle.

Test Plan:
1. Reset, then SYSTICK reads:
   - Assert reset 2 cycles, release.
   - Read 0x40000014 at cycles 1 and 11 after release → difference 10.
   - led=0, digits=0, irq=0.
2. LED/DIGITS store and load:
   - Store 32'hABCD1234 to 0x4000000C → led=16'h1234 next cycle; load returns 32'h00001234.
   - Store 32'h00005678 to 0x40000010 → digits=16'h5678.
3. Timer overflow and reload:
   - TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3, PRESCALE=1.
   - TL reads FFFFFFFF, then FFFFFFFC; IS=1 and irq=1 at the reload edge.
   - Write TCON=3 → irq=0.
4. Collision:
   - Timer enabled; store 32'h00000010 to TL in the same cycle as a tick → TL=0x10, then 0x11.
   - Overflow coinciding with a TCON write of 3 → IS stays 1.
5. Prescaler:
   - PRESCALE=4, TL=0, TCON=1 → TL=1 after 4 cycles, 2 after 8.
   - TCON=0 → TL frozen.
6. Decode edges:
   - Address 0x40000018 → hit=0, ReadData=0, no register changes.
   - Address 0x40000007 → accesses TL.
   - 0x3FFFFFFC → hit=0.
   - Mid-count reset → TL=0, irq=0.
